pipe_flow_ctrl: RTL and testbench

//  Central flow controller for the IF/ID and ID/EX pipeline registers. Merges the decode-stage hazard,

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_flow_ctrl_if.sv | 35 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_flow_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline flow controller and Decode.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2,
        STEP  = 2'd3
    } pfc_state_t;

    localparam int PFC_DRAIN_DEF = 4;

    // ID/EX bubble encoding: every control bit zero except alusrc.
    localparam logic       ID_EX_BUBBLE_ALUSRC = 1'b1;
    localparam logic [7:0] ID_EX_BUBBLE_CTRL   = 8'h00;

    // Pipeline register control word produced each cycle.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
    } pfc_ctrl_t;

    localparam pfc_ctrl_t CTRL_IDLE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pfc_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam pfc_ctrl_t CTRL_TRAP   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam pfc_ctrl_t CTRL_HZ     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam pfc_ctrl_t CTRL_BRANCH = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam pfc_ctrl_t CTRL_DRAIN  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// Hazard/debug request inputs and pipeline-register controls between Decode and the flow controller.
interface pipe_flow_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hz;
    logic             branch_taken;
    logic             trigger_trap;
    logic             mem_hold;
    logic             dbg_req;
    logic             dbg_step;
    logic             dbg_resume;
    logic             stall_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_bubble;
    logic             halted;
    logic             dbg_ack;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output hz, branch_taken, trigger_trap, mem_hold,
               dbg_req, dbg_step, dbg_resume, stall_clr,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               halted, dbg_ack, stall_cnt
    );

    modport slave (
        input  hz, branch_taken, trigger_trap, mem_hold,
               dbg_req, dbg_step, dbg_resume, stall_clr,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               halted, dbg_ack, stall_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count up on en, stick at all-ones, clear has priority.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Central IF/ID and ID/EX flow controller with debug halt/step sequencing.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  RUN   | normal flow, priority mux mem_hold > trap > hz > branch
//  DRAIN | fetch stopped, bubbles pushed until drain_cnt expires
//  HALT  | core halted for debug, all enables low
//  STEP  | one instruction released, then back to DRAIN
module pipe_flow_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = PFC_DRAIN_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             Rst,
    pipe_flow_ctrl_if.slave  bus
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    pfc_state_t state;
    logic [3:0] drain_cnt;
    logic       trap_pend;
    logic       halted_q;
    logic       dbg_ack_q;
    logic       trap_act;
    logic       stall_inc;
    pfc_ctrl_t  ctrl;

    // A trap parked during a memory hold is replayed on the first free cycle.
    assign trap_act = bus.trigger_trap | trap_pend;

    // Priority mux for the pipeline register controls, forced idle in reset.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (Rst && !bus.mem_hold) begin
            unique case (state)
                RUN: begin
                    if (trap_act)              ctrl = CTRL_TRAP;
                    else if (bus.hz)           ctrl = CTRL_HZ;
                    else if (bus.branch_taken) ctrl = CTRL_BRANCH;
                    else                       ctrl = CTRL_NORMAL;
                end
                DRAIN: begin
                    if (trap_act)              ctrl = CTRL_TRAP;
                    else if (bus.hz)           ctrl = CTRL_HZ;
                    else                       ctrl = CTRL_DRAIN;
                end
                STEP:    ctrl = CTRL_NORMAL;
                default: ctrl = CTRL_IDLE;
            endcase
        end
    end

    // Only cycles where the hazard rule actually wins are counted as stalls.
    assign stall_inc = Rst && !bus.mem_hold && !trap_act && bus.hz &&
                       ((state == RUN) || (state == DRAIN));

    // Debug sequencing FSM with drain down-counter and registered halt/ack.
    always_ff @(posedge clk) begin
        if (!Rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            trap_pend <= 1'b0;
            halted_q  <= 1'b0;
            dbg_ack_q <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;

            if (bus.mem_hold)
                trap_pend <= trap_pend | bus.trigger_trap;
            else if ((state == RUN) || (state == DRAIN))
                trap_pend <= 1'b0;
            else
                trap_pend <= trap_pend | bus.trigger_trap;

            unique case (state)
                RUN: begin
                    if (!bus.mem_hold && bus.dbg_req) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (!bus.mem_hold) begin
                        if (trap_act) begin
                            drain_cnt <= DRAIN_LOAD;
                        end else if (!bus.hz) begin
                            if (drain_cnt <= 4'd1) begin
                                state     <= HALT;
                                drain_cnt <= '0;
                                halted_q  <= 1'b1;
                                dbg_ack_q <= 1'b1;
                            end else begin
                                drain_cnt <= drain_cnt - 4'd1;
                            end
                        end
                    end
                end
                HALT: begin
                    if (bus.dbg_resume) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end else if (bus.dbg_step) begin
                        state    <= STEP;
                        halted_q <= 1'b0;
                    end
                end
                STEP: begin
                    if (!bus.mem_hold) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_b (Rst),
        .en    (stall_inc),
        .clr   (bus.stall_clr),
        .q     (bus.stall_cnt)
    );

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.id_ex_bubble = ctrl.id_ex_bubble;
    assign bus.halted       = halted_q;
    assign bus.dbg_ack      = dbg_ack_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed self-checking bench for pipe_flow_ctrl.
module tb_pipe_flow_ctrl;

    localparam logic [4:0] O_ZERO = 5'b00000;
    localparam logic [4:0] O_NORM = 5'b11010;
    localparam logic [4:0] O_HZ   = 5'b00011;
    localparam logic [4:0] O_TRAP = 5'b10111;
    localparam logic [4:0] O_BR   = 5'b10110;
    localparam logic [4:0] O_DRN  = 5'b00110;

    logic clk;
    logic Rst;
    int   compared;
    int   mismatched;

    pipe_flow_ctrl_if #(.CNT_W(16)) bus ();

    pipe_flow_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    logic [4:0] o;
    assign o = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hz = 0; bus.branch_taken = 0; bus.trigger_trap = 0; bus.mem_hold = 0;
        bus.dbg_req = 0; bus.dbg_step = 0; bus.dbg_resume = 0; bus.stall_clr = 0;
    endtask

    task automatic test_reset();
        Rst = 0;
        bus.hz = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            compared++;
            if (o !== O_ZERO) begin
                mismatched++; $display("FAIL reset_ctl cyc%0d got=%b want=%b", i, o, O_ZERO);
            end
            compared++;
            if ({bus.halted, bus.dbg_ack} !== 2'b00 || bus.stall_cnt !== 16'd0) begin
                mismatched++; $display("FAIL reset_regs cyc%0d got halted=%b ack=%b cnt=%0d want 0/0/0",
                                       i, bus.halted, bus.dbg_ack, bus.stall_cnt);
            end
        end
        Rst = 1;
        bus.hz = 0;
        #1;
        compared++;
        if (o !== O_NORM) begin
            mismatched++; $display("FAIL reset_release got=%b want=%b", o, O_NORM);
        end
        tick();
    endtask

    task automatic test_hazard();
        bus.hz = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (o !== O_HZ || bus.stall_cnt !== 16'(i)) begin
                mismatched++; $display("FAIL hz_cyc%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                                       i, o, bus.stall_cnt, O_HZ, i);
            end
            tick();
        end
        bus.hz = 0;
        #1;
        compared++;
        if (o !== O_NORM || bus.stall_cnt !== 16'd3) begin
            mismatched++; $display("FAIL hz_after got ctl=%b cnt=%0d want ctl=%b cnt=3", o, bus.stall_cnt, O_NORM);
        end
        // clear beats a simultaneous increment
        bus.hz = 1;
        bus.stall_clr = 1;
        tick();
        bus.hz = 0;
        bus.stall_clr = 0;
        #1;
        compared++;
        if (bus.stall_cnt !== 16'd0) begin
            mismatched++; $display("FAIL stall_clr got=%0d want=0", bus.stall_cnt);
        end
        tick();
    endtask

    task automatic test_priority();
        bus.hz = 1; bus.branch_taken = 1;
        #1;
        compared++;
        if (o !== O_HZ) begin
            mismatched++; $display("FAIL prio_hz_br got=%b want=%b", o, O_HZ);
        end
        tick();
        bus.hz = 0;
        #1;
        compared++;
        if (o !== O_BR || bus.stall_cnt !== 16'd1) begin
            mismatched++; $display("FAIL prio_br got ctl=%b cnt=%0d want ctl=%b cnt=1", o, bus.stall_cnt, O_BR);
        end
        tick();
        bus.hz = 1; bus.trigger_trap = 1;
        #1;
        compared++;
        if (o !== O_TRAP) begin
            mismatched++; $display("FAIL prio_trap got=%b want=%b", o, O_TRAP);
        end
        tick();
        idle_inputs();
        #1;
        compared++;
        if (o !== O_NORM || bus.stall_cnt !== 16'd1) begin
            mismatched++; $display("FAIL prio_after got ctl=%b cnt=%0d want ctl=%b cnt=1", o, bus.stall_cnt, O_NORM);
        end
        bus.stall_clr = 1;
        tick();
        bus.stall_clr = 0;
    endtask

    task automatic test_trap_hold();
        bus.mem_hold = 1; bus.trigger_trap = 1; bus.hz = 1;
        #1;
        compared++;
        if (o !== O_ZERO) begin
            mismatched++; $display("FAIL hold_trap_c0 got=%b want=%b", o, O_ZERO);
        end
        tick();
        bus.trigger_trap = 0; bus.hz = 0;
        #1;
        compared++;
        if (o !== O_ZERO || bus.stall_cnt !== 16'd0) begin
            mismatched++; $display("FAIL hold_trap_c1 got ctl=%b cnt=%0d want ctl=%b cnt=0", o, bus.stall_cnt, O_ZERO);
        end
        tick();
        bus.mem_hold = 0;
        #1;
        compared++;
        if (o !== O_TRAP) begin
            mismatched++; $display("FAIL hold_trap_apply got=%b want=%b", o, O_TRAP);
        end
        tick();
        #1;
        compared++;
        if (o !== O_NORM) begin
            mismatched++; $display("FAIL hold_trap_once got=%b want=%b", o, O_NORM);
        end
        tick();
    endtask

    task automatic test_dbg_halt();
        bus.dbg_req = 1;
        #1;
        compared++;
        if (o !== O_NORM) begin
            mismatched++; $display("FAIL halt_req_cycle got=%b want=%b", o, O_NORM);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (o !== O_DRN || bus.halted !== 1'b0 || bus.dbg_ack !== 1'b0) begin
                mismatched++; $display("FAIL halt_drain%0d got ctl=%b halted=%b ack=%b want ctl=%b 0 0",
                                       i, o, bus.halted, bus.dbg_ack, O_DRN);
            end
            tick();
        end
        #1;
        compared++;
        if (o !== O_ZERO || bus.halted !== 1'b1 || bus.dbg_ack !== 1'b1) begin
            mismatched++; $display("FAIL halt_entry got ctl=%b halted=%b ack=%b want ctl=%b 1 1",
                                   o, bus.halted, bus.dbg_ack, O_ZERO);
        end
        tick();
        bus.dbg_req = 0;
        #1;
        compared++;
        if (bus.halted !== 1'b1 || bus.dbg_ack !== 1'b0 || o !== O_ZERO) begin
            mismatched++; $display("FAIL halt_ack_pulse got ctl=%b halted=%b ack=%b want ctl=%b 1 0",
                                   o, bus.halted, bus.dbg_ack, O_ZERO);
        end
    endtask

    task automatic test_step();
        bus.dbg_step = 1;
        tick();
        bus.dbg_step = 0;
        #1;
        compared++;
        if (o !== O_NORM || bus.halted !== 1'b0) begin
            mismatched++; $display("FAIL step_cycle got ctl=%b halted=%b want ctl=%b halted=0", o, bus.halted, O_NORM);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (o !== O_DRN || bus.halted !== 1'b0) begin
                mismatched++; $display("FAIL step_drain%0d got ctl=%b halted=%b want ctl=%b halted=0",
                                       i, o, bus.halted, O_DRN);
            end
            tick();
        end
        #1;
        compared++;
        if (bus.halted !== 1'b1 || bus.dbg_ack !== 1'b1) begin
            mismatched++; $display("FAIL step_rehalt got halted=%b ack=%b want 1 1", bus.halted, bus.dbg_ack);
        end
        bus.dbg_step = 1; bus.dbg_resume = 1;
        tick();
        idle_inputs();
        #1;
        compared++;
        if (o !== O_NORM || bus.halted !== 1'b0) begin
            mismatched++; $display("FAIL resume_wins got ctl=%b halted=%b want ctl=%b halted=0", o, bus.halted, O_NORM);
        end
        tick();
        #1;
        compared++;
        if (o !== O_NORM) begin
            mismatched++; $display("FAIL resume_stays_run got=%b want=%b", o, O_NORM);
        end
        tick();
    endtask

    task automatic test_drain_hz_trap();
        logic [4:0] exp_seq [6];
        exp_seq = '{O_DRN, O_HZ, O_HZ, O_DRN, O_DRN, O_DRN};
        bus.dbg_req = 1;
        tick();
        bus.dbg_req = 0;
        for (int i = 0; i < 6; i++) begin
            bus.hz = (i == 1 || i == 2);
            #1;
            compared++;
            if (o !== exp_seq[i] || bus.halted !== 1'b0) begin
                mismatched++; $display("FAIL drain_hz%0d got ctl=%b halted=%b want ctl=%b halted=0",
                                       i, o, bus.halted, exp_seq[i]);
            end
            tick();
        end
        bus.hz = 0;
        #1;
        compared++;
        if (bus.halted !== 1'b1 || bus.stall_cnt !== 16'd2) begin
            mismatched++; $display("FAIL drain_hz_halt got halted=%b cnt=%0d want halted=1 cnt=2",
                                   bus.halted, bus.stall_cnt);
        end
        bus.dbg_resume = 1;
        tick();
        bus.dbg_resume = 0;
        bus.dbg_req = 1;
        tick();
        bus.dbg_req = 0;
        tick();
        tick();
        bus.trigger_trap = 1;
        #1;
        compared++;
        if (o !== O_TRAP) begin
            mismatched++; $display("FAIL drain_trap got=%b want=%b", o, O_TRAP);
        end
        tick();
        bus.trigger_trap = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (o !== O_DRN || bus.halted !== 1'b0) begin
                mismatched++; $display("FAIL drain_reload%0d got ctl=%b halted=%b want ctl=%b halted=0",
                                       i, o, bus.halted, O_DRN);
            end
            tick();
        end
        #1;
        compared++;
        if (bus.halted !== 1'b1) begin
            mismatched++; $display("FAIL drain_reload_halt got halted=%b want 1", bus.halted);
        end
        bus.dbg_resume = 1;
        tick();
        bus.dbg_resume = 0;
    endtask

    task automatic test_reset_in_drain();
        bus.dbg_req = 1;
        tick();
        bus.dbg_req = 0;
        tick();
        Rst = 0;
        #1;
        compared++;
        if (o !== O_ZERO) begin
            mismatched++; $display("FAIL rst_drain_force got=%b want=%b", o, O_ZERO);
        end
        tick();
        Rst = 1;
        #1;
        compared++;
        if (o !== O_NORM || bus.halted !== 1'b0 || bus.stall_cnt !== 16'd0) begin
            mismatched++; $display("FAIL rst_drain_run got ctl=%b halted=%b cnt=%0d want ctl=%b 0 0",
                                   o, bus.halted, bus.stall_cnt, O_NORM);
        end
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        Rst = 0;
        idle_inputs();
        test_reset();
        test_hazard();
        test_priority();
        test_trap_hold();
        test_dbg_halt();
        test_step();
        test_drain_hz_trap();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
